rr_onehot_arb: RTL and testbench

- Round-robin arbiter sharing one downstream valid/ready port between NUM_REQ requesters.
- Internally builds a one-hot grant vector. It encodes that vector to a binary index and uses the one-hot vector directly as an AND-OR data mux.
- Sits in front of shared common_cells resources such as FIFOs and memory ports. A rotating priority pointer provides fairness.

---
 rtl/rr_onehot_arb.sv | 118 +++++++++++
 tb/tb_rr_onehot_arb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter: one-hot grant, binary index and AND-OR payload mux onto one valid/ready port.
// Optional grant lock while downstream stalls: define RR_ARB_LOCK_EN.
module rr_onehot_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic [IDX_WIDTH-1:0]          idx_o,
    output logic [NUM_REQ-1:0]            onehot_o
);

    logic [IDX_WIDTH-1:0] prio_q, prio_d;
    logic [NUM_REQ-1:0]   scan_oh;
    logic                 scan_found;
    int unsigned          scan_k;

    // Scan from prio_q upwards; prio_q < NUM_REQ so one subtraction handles the wrap.
    always_comb begin
        scan_oh    = '0;
        scan_found = 1'b0;
        scan_k     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_k = 32'(prio_q) + i;
            if (scan_k >= NUM_REQ) scan_k = scan_k - NUM_REQ;
            if (!scan_found && req_i[scan_k]) begin
                scan_oh[scan_k] = 1'b1;
                scan_found      = 1'b1;
            end
        end
    end

`ifdef RR_ARB_LOCK_EN
    logic               lock_q, lock_d;
    logic [NUM_REQ-1:0] onehot_q, onehot_d;

    assign onehot_o = lock_q ? onehot_q : scan_oh;

    always_comb begin
        lock_d   = lock_q;
        onehot_d = onehot_q;
        if (flush_i) begin
            lock_d = 1'b0;
        end else if (valid_o) begin
            if (ready_i) begin
                lock_d = 1'b0;
            end else begin
                lock_d   = 1'b1;
                onehot_d = onehot_o;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q   <= 1'b0;
            onehot_q <= '0;
        end else begin
            lock_q   <= lock_d;
            onehot_q <= onehot_d;
        end
    end
`else
    assign onehot_o = scan_oh;
`endif

    always_comb begin
        idx_o  = '0;
        data_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (onehot_o[k]) begin
                idx_o  = idx_o | IDX_WIDTH'(k);
                data_o = data_o | data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign valid_o = |onehot_o;
    assign gnt_o   = onehot_o & {NUM_REQ{ready_i}};

    always_comb begin
        prio_d = prio_q;
        if (flush_i) begin
            prio_d = '0;
        end else if (valid_o && ready_i) begin
            if (32'(idx_o) == NUM_REQ - 1) prio_d = '0;
            else                           prio_d = idx_o + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) prio_q <= '0;
        else       prio_q <= prio_d;
    end

`ifndef FORMAL
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($onehot0(onehot_o)) else $error("onehot_o not onehot0: %b", onehot_o);
            assert (valid_o ? onehot_o[idx_o] : (idx_o == '0))
                else $error("idx_o %0d inconsistent with onehot_o %b", idx_o, onehot_o);
`ifdef RR_ARB_LOCK_EN
            assert (!lock_q || |(onehot_q & req_i))
                else $error("locked requester dropped req_i: %b", onehot_q);
`endif
        end
    end
`endif

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Scoreboard bench for rr_onehot_arb: NUM_REQ=4 and NUM_REQ=3 instances, directed vectors.
// Expectations adapt to RR_ARB_LOCK_EN when the bench is built with that macro.
module tb_rr_onehot_arb;

`ifdef RR_ARB_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    typedef struct {
        int          sel;
        logic        v;
        logic [1:0]  idx;
        logic [31:0] d;
        logic [3:0]  g;
        logic [3:0]  oh;
        int          n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush4 = 1'b0;
    logic [3:0]   req4 = '0;
    logic         ready4 = 1'b0;
    logic [127:0] data4;
    logic [3:0]   gnt4, oh4;
    logic         valid4;
    logic [31:0]  dout4;
    logic [1:0]   idx4;

    logic [2:0]   req3 = '0;
    logic         ready3 = 1'b0;
    logic [95:0]  data3;
    logic [2:0]   gnt3, oh3;
    logic         valid3;
    logic [31:0]  dout3;
    logic [1:0]   idx3;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_push = 0;

    always #5 clk = ~clk;

    assign data4 = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    assign data3 = {32'h3E3E_0002, 32'h3E3E_0001, 32'h3E3E_0000};

    rr_onehot_arb #(.NUM_REQ(4), .DATA_WIDTH(32)) dut4 (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush4),
        .req_i   (req4),
        .data_i  (data4),
        .gnt_o   (gnt4),
        .valid_o (valid4),
        .ready_i (ready4),
        .data_o  (dout4),
        .idx_o   (idx4),
        .onehot_o(oh4)
    );

    rr_onehot_arb #(.NUM_REQ(3), .DATA_WIDTH(32)) dut3 (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (1'b0),
        .req_i   (req3),
        .data_i  (data3),
        .gnt_o   (gnt3),
        .valid_o (valid3),
        .ready_i (ready3),
        .data_o  (dout3),
        .idx_o   (idx3),
        .onehot_o(oh3)
    );

    task automatic push(input int sel, input logic rdy, input logic v, input int idx);
        exp_t e;
        e.sel = sel;
        e.v   = v;
        e.idx = v ? 2'(idx) : 2'd0;
        e.oh  = v ? (4'b0001 << idx) : 4'b0000;
        e.g   = rdy ? e.oh : 4'b0000;
        if (!v)            e.d = 32'h0;
        else if (sel == 0) e.d = 32'hC0DE_0000 | 32'(idx);
        else               e.d = 32'h3E3E_0000 | 32'(idx);
        e.n = n_push;
        n_push++;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs just after the rising edge; rst may be raised mid-cycle here.
    task automatic drive(input int sel, input logic r, input logic f, input logic [3:0] rq,
                         input logic rdy, input logic v, input int idx);
        @(posedge clk);
        #1;
        rst    = r;
        flush4 = (sel == 0) ? f : 1'b0;
        req4   = (sel == 0) ? rq : 4'b0000;
        ready4 = (sel == 0) ? rdy : 1'b0;
        req3   = (sel == 1) ? rq[2:0] : 3'b000;
        ready3 = (sel == 1) ? rdy : 1'b0;
        push(sel, rdy, v, idx);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic        a_v;
            logic [1:0]  a_idx;
            logic [31:0] a_d;
            logic [3:0]  a_g, a_oh;
            e = q.pop_front();
            if (e.sel == 0) begin
                a_v = valid4; a_idx = idx4; a_d = dout4; a_g = gnt4; a_oh = oh4;
            end else begin
                a_v = valid3; a_idx = idx3; a_d = dout3; a_g = {1'b0, gnt3}; a_oh = {1'b0, oh3};
            end
            n_vec++;
            if (a_v !== e.v || a_idx !== e.idx || a_d !== e.d || a_g !== e.g || a_oh !== e.oh) begin
                n_bad++;
                $display("FAIL vec%0d dut%0d: got v=%b idx=%0d data=%h gnt=%b oh=%b, want v=%b idx=%0d data=%h gnt=%b oh=%b",
                         e.n, (e.sel == 0) ? 4 : 3, a_v, a_idx, a_d, a_g, a_oh,
                         e.v, e.idx, e.d, e.g, e.oh);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // In reset with no requests: everything quiet on both instances.
        push(0, 1'b0, 1'b0, 0);
        push(1, 1'b0, 1'b0, 0);

        drive(0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 0);

        // NUM_REQ=3 with requesters 0 and 2: pointer wraps 2 -> 0.
        for (int i = 0; i < 4; i++) drive(1, 1'b0, 1'b0, 4'b0101, 1'b1, 1'b1, (i % 2) * 2);

        // All four requesting with ready: full rotation twice.
        for (int i = 0; i < 8; i++) drive(0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, i % 4);

        // Stall on requester 1, then requester 0 joins with higher priority.
        for (int i = 0; i < 3; i++) drive(0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1);
        drive(0, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b1, LockEn ? 1 : 0);
        drive(0, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b1, LockEn ? 1 : 0);
        drive(0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 0);

        // Handshake on 2 (prio -> 3), then flush: same-cycle idx 3, next cycle idx 0.
        drive(0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 2);
        drive(0, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 3);
        drive(0, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b1, 0);
        drive(0, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b1, 0);
        drive(0, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b1, 3);

        // prio -> 1, stall on 3 (locks if enabled), then async reset mid-cycle.
        drive(0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 0);
        drive(0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 3);
        drive(0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 3);
        drive(0, 1'b1, 1'b0, 4'b1001, 1'b0, 1'b1, 0);
        drive(0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 3);
        drive(0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1, 3);
        drive(0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 0);

        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
